// File: rtl/mode_seq_pkg.sv
// mode_seq_pkg: shared state encoding, guard counter width and one-hot helper
package mode_seq_pkg;
    typedef enum logic [1:0] {RUN, GUARD, ENTER} state_t;
    localparam int GUARD_W = 8;
    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction
endpackage

// File: rtl/rise_edge.sv
// rise_edge: registered rising-edge detector whose history resets high
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic prev;
    always_ff @(posedge clk) prev <= !rst_n ? 1'b1 : d;
    assign rise = d & ~prev;
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: guarded one-hot mode switcher; MODE_SEQ_LOCK_EN adds a lock input
module mode_sequencer import mode_seq_pkg::*; #(
    parameter  int NUM_MODES    = 3,
    parameter  int GUARD_CYCLES = 2,
    parameter  int RESET_MODE   = 0,
    localparam int SEL_W        = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef MODE_SEQ_LOCK_EN
    input  logic                 lock,
`endif
    input  logic                 adv_btn,
    input  logic                 sel_load,
    input  logic [SEL_W-1:0]     sel_in,
    output logic [NUM_MODES-1:0] mode_en,
    output logic [SEL_W-1:0]     mode_idx,
    output logic [NUM_MODES-1:0] mode_rst,
    output logic                 switching
);
    state_t               state, state_d;
    logic [GUARD_W-1:0]   cnt, cnt_d;
    logic [SEL_W-1:0]     target, target_d, mode_idx_d, adv_tgt;
    logic [NUM_MODES-1:0] mode_oh, mode_en_d, mode_rst_d;
    logic                 switching_d, adv_edge, sel_ok, req, locked;
`ifdef MODE_SEQ_LOCK_EN
    assign locked = lock;
`else
    assign locked = 1'b0;
`endif
    rise_edge u_adv (.clk(clk), .rst_n(rst_n), .d(adv_btn), .rise(adv_edge));
    assign adv_tgt = (mode_idx == SEL_W'(NUM_MODES - 1)) ? '0 : mode_idx + SEL_W'(1);
    assign sel_ok  = sel_load && (32'(sel_in) < NUM_MODES) && (sel_in != mode_idx);
    assign req     = (sel_ok || adv_edge) && !locked;
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        target_d = target;
        if (state == RUN && req) begin
            state_d  = GUARD;
            cnt_d    = GUARD_W'(GUARD_CYCLES - 1);
            target_d = sel_ok ? sel_in : adv_tgt;
        end else if (state == GUARD) begin
            state_d = (cnt == '0) ? ENTER : GUARD;
            cnt_d   = (cnt == '0) ? '0 : cnt - GUARD_W'(1);
        end else if (state == ENTER) begin
            state_d = RUN;
        end
    end
    always_comb begin
        mode_idx_d  = (state_d == ENTER) ? target_d : mode_idx;
        mode_oh     = NUM_MODES'(onehot(4'(mode_idx_d)));
        mode_en_d   = (state_d == GUARD) ? '0 : mode_oh;
        mode_rst_d  = (state_d == ENTER) ? mode_oh : '0;
        switching_d = state_d != RUN;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            target    <= SEL_W'(RESET_MODE);
            mode_idx  <= SEL_W'(RESET_MODE);
            mode_en   <= NUM_MODES'(1) << RESET_MODE;
            mode_rst  <= '0;
            switching <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            target    <= target_d;
            mode_idx  <= mode_idx_d;
            mode_en   <= mode_en_d;
            mode_rst  <= mode_rst_d;
            switching <= switching_d;
        end
    end
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed stimulus checked against a cycle-count model
module tb_mode_sequencer;
    localparam int N = 3;
    localparam int G = 2;
    localparam int RM = 0;
    localparam int SW = 2;
    logic          clk = 0;
    logic          rst_n, adv_btn, sel_load, lk;
    logic [SW-1:0] sel_in;
    logic [N-1:0]  mode_en, mode_rst;
    logic [SW-1:0] mode_idx;
    logic          switching;
    int            n_cmp = 0, n_bad = 0, pulses = 0;
    int            m_mode = 0, m_k = 0, m_tgt = 0, m_prev = 1;
    always #5 clk = ~clk;
    mode_sequencer #(.NUM_MODES(N), .GUARD_CYCLES(G), .RESET_MODE(RM)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef MODE_SEQ_LOCK_EN
        .lock(lk),
`endif
        .adv_btn(adv_btn),
        .sel_load(sel_load),
        .sel_in(sel_in),
        .mode_en(mode_en),
        .mode_idx(mode_idx),
        .mode_rst(mode_rst),
        .switching(switching)
    );
    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode <= RM;
            m_k    <= 0;
            m_tgt  <= RM;
            m_prev <= 1;
        end else begin
            m_prev <= int'(adv_btn);
            if (m_k == 0) begin
                if (!lk && sel_load && int'(sel_in) < N && int'(sel_in) != m_mode) begin
                    m_k   <= 1;
                    m_tgt <= int'(sel_in);
                end else if (!lk && adv_btn && m_prev == 0) begin
                    m_k   <= 1;
                    m_tgt <= (m_mode + 1) % N;
                end
            end else if (m_k <= G) begin
                m_k <= m_k + 1;
                if (m_k == G) m_mode <= m_tgt;
            end else begin
                m_k <= 0;
            end
        end
    end
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic cyc(input logic r, input logic a, input logic sl, input int si);
        @(negedge clk);
        chk("model_en", int'(mode_en), (m_k >= 1 && m_k <= G) ? 0 : (1 << m_mode));
        chk("model_rst", int'(mode_rst), (m_k == G + 1) ? (1 << m_mode) : 0);
        chk("model_idx", int'(mode_idx), m_mode);
        chk("model_sw", int'(switching), int'(m_k != 0));
        if (mode_rst != '0) pulses++;
        rst_n    = r;
        adv_btn  = a;
        sel_load = sl;
        sel_in   = SW'(si);
    endtask
    initial begin
        rst_n = 0; adv_btn = 1; sel_load = 0; sel_in = 0; lk = 0;
        repeat (2) cyc(0, 1, 0, 0);
        chk("reset_en", int'(mode_en), 1);
        chk("reset_sw", int'(switching), 0);
        repeat (10) cyc(1, 1, 0, 0);
        chk("held_en", int'(mode_en), 1);
        chk("held_idx", int'(mode_idx), 0);
        chk("held_sw", int'(switching), 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("t1_en", int'(mode_en), 0);
        chk("t1_sw", int'(switching), 1);
        cyc(1, 1, 0, 0);
        chk("t2_en", int'(mode_en), 0);
        cyc(1, 1, 0, 0);
        chk("t3_en", int'(mode_en), 2);
        chk("t3_rst", int'(mode_rst), 2);
        chk("t3_idx", int'(mode_idx), 1);
        cyc(1, 1, 0, 0);
        chk("t4_rst", int'(mode_rst), 0);
        chk("t4_sw", int'(switching), 0);
        chk("t4_en", int'(mode_en), 2);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0);
            repeat (6) cyc(1, 1, 0, 0);
        end
        chk("wrap_idx", int'(mode_idx), 0);
        chk("wrap_pulses", pulses, 2);
        cyc(1, 0, 1, 3);
        cyc(1, 0, 0, 0);
        chk("bad_sel_sw", int'(switching), 0);
        cyc(1, 1, 1, 2);
        repeat (5) cyc(1, 1, 0, 0);
        chk("sel_prio_idx", int'(mode_idx), 2);
        cyc(1, 0, 1, 2);
        cyc(1, 0, 0, 0);
        chk("same_sel_sw", int'(switching), 0);
        cyc(1, 0, 1, 0);
        repeat (5) cyc(1, 0, 0, 0);
        chk("sel0_idx", int'(mode_idx), 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (5) cyc(1, 1, 0, 0);
        chk("guard_drop_idx", int'(mode_idx), 1);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (5) cyc(1, 1, 0, 0);
        chk("enter_drop_idx", int'(mode_idx), 2);
        pulses = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("abort_en", int'(mode_en), 1);
        chk("abort_sw", int'(switching), 0);
        chk("abort_idx", int'(mode_idx), 0);
        repeat (5) cyc(1, 1, 0, 0);
        chk("abort_pulses", pulses, 0);
`ifdef MODE_SEQ_LOCK_EN
        lk = 1;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (5) cyc(1, 1, 0, 0);
        chk("lock_idx", int'(mode_idx), 0);
        chk("lock_sw", int'(switching), 0);
        lk = 0;
`endif
        repeat (3) cyc(1, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
